// File: rtl/deadlock_pkg.sv
// Shared types and helpers for the deadlock report controller.
// ch_field accepts vectors up to DL_MAX_CH channels; callers zero-extend.
package deadlock_pkg;

  localparam int unsigned DL_MAX_CH  = 64;
  localparam int unsigned DL_VEC_W   = 2 * DL_MAX_CH;

  localparam logic [1:0] BLK_NONE = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } dl_state_t;

  // Extract the 2-bit block code of channel k from a packed info vector.
  function automatic logic [1:0] ch_field(input logic [DL_VEC_W-1:0] vec,
                                          input int unsigned         k);
    return vec[2*k +: 2];
  endfunction

endpackage

// File: rtl/dl_chan_scan.sv
// Combinational finder for the lowest-indexed channel whose snapshot code
// is non-zero and whose record has not yet been sent. last is set when no
// higher pending channel remains after the one found.
module dl_chan_scan
  import deadlock_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned IW     = $clog2(NUM_CH)
) (
  input  logic [2*NUM_CH-1:0] snap,
  input  logic [NUM_CH-1:0]   sent,
  output logic [IW-1:0]       idx,
  output logic                found,
  output logic                last
);

  logic [DL_VEC_W-1:0] snap_ext;

  assign snap_ext = DL_VEC_W'(snap);

  // Priority scan: first pending channel wins, any later one clears last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    last  = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if ((ch_field(snap_ext, k) != BLK_NONE) && !sent[k]) begin
        if (!found) begin
          idx   = IW'(k);
          found = 1'b1;
          last  = 1'b1;
        end else begin
          last  = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/deadlock_report_ctrl.sv
// Deadlock report controller: debounces the monitor's block flag, snapshots
// per-channel block info on detection, and streams one record per blocked
// channel. Optional macro DEADLOCK_REARM_EN lets DONE re-arm when block
// drops; without it DONE exits only through clear or reset.
module deadlock_report_ctrl
  import deadlock_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned THRESH = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      block,
  input  logic [2*NUM_CH-1:0]       axis_block_info,
  input  logic                      clear,
  output logic                      rpt_valid,
  input  logic                      rpt_ready,
  output logic [$clog2(NUM_CH)-1:0] rpt_chan,
  output logic [1:0]                rpt_code,
  output logic                      rpt_last,
  output logic                      deadlock,
  output logic [CNT_W-1:0]          stall_cycles
);

  localparam int unsigned IW = $clog2(NUM_CH);

  dl_state_t            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*NUM_CH-1:0]  snap_q;
  logic [NUM_CH-1:0]    sent_q;
  logic                 dl_q;

  logic [IW-1:0]        scan_idx;
  logic                 scan_found;
  logic                 scan_last;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 hit_thresh;
  logic                 handshake;

  dl_chan_scan #(
    .NUM_CH (NUM_CH),
    .IW     (IW)
  ) u_scan (
    .snap  (snap_q),
    .sent  (sent_q),
    .idx   (scan_idx),
    .found (scan_found),
    .last  (scan_last)
  );

  // Saturating increment and detection compare for the stall counter.
  always_comb begin
    cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    hit_thresh = (cnt_q == CNT_W'(THRESH - 1));
    handshake  = rpt_valid && rpt_ready;
  end

  // Record outputs come straight from registered state, so they hold
  // steady under backpressure; they read zero whenever no record is valid.
  always_comb begin
    rpt_valid = (state_q == EMIT) && scan_found;
    rpt_chan  = '0;
    rpt_code  = BLK_NONE;
    rpt_last  = 1'b0;
    if (rpt_valid) begin
      rpt_chan = scan_idx;
      rpt_code = ch_field(DL_VEC_W'(snap_q), 32'(scan_idx));
      rpt_last = scan_last;
    end
  end

  assign deadlock     = dl_q;
  assign stall_cycles = cnt_q;

  // Main FSM: clear overrides every state; counter is frozen after detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      snap_q  <= '0;
      sent_q  <= '0;
      dl_q    <= 1'b0;
    end else if (clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      snap_q  <= '0;
      sent_q  <= '0;
      dl_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (block) begin
            state_q <= ARM;
            cnt_q   <= CNT_W'(1);
          end else begin
            cnt_q   <= '0;
          end
        end
        ARM: begin
          if (!block) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
            if (hit_thresh) begin
              snap_q  <= axis_block_info;
              sent_q  <= '0;
              dl_q    <= 1'b1;
              state_q <= (axis_block_info != '0) ? EMIT : DONE;
            end
          end
        end
        EMIT: begin
          if (handshake) begin
            sent_q <= sent_q | (NUM_CH'(1) << scan_idx);
            if (rpt_last) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
`ifdef DEADLOCK_REARM_EN
          if (!block) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            snap_q  <= '0;
            sent_q  <= '0;
            dl_q    <= 1'b0;
          end
`else
          state_q <= DONE;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/deadlock_report_ctrl.md
Name: deadlock_report_ctrl

Overview:
- Consumer end of the dataflow deadlock-monitor interface. Takes the monitor's `block` flag and its per-channel AXIS block-info vector.
- Filters out transient stalls: a deadlock is declared only after `block` stays high for THRESH consecutive cycles.
- On declaration, snapshots the block-info vector and emits one report record per blocked AXIS channel over a valid/ready stream to the testbench logger.
- Holds a sticky deadlock flag until cleared.

Parameters:
- NUM_CH, 2: number of AXIS channels watched. Must be ≥2.
- THRESH, 16: consecutive high cycles of `block` required to declare deadlock. Must be ≥2.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- block  in  1  deadlock candidate flag from the monitor.
- axis_block_info  in  2*NUM_CH  per-channel 2-bit block code. Field k is bits [2k+1:2k]; 2'b00 means not blocked.
- clear  in  1  synchronous clear/re-arm pulse.
- rpt_valid  out  1  report record valid.
- rpt_ready  in  1  report record accepted.
- rpt_chan  out  $clog2(NUM_CH)  channel index of the record.
- rpt_code  out  2  snapshot code of that channel.
- rpt_last  out  1  final record of this report.
- deadlock  out  1  sticky deadlock declared.
- stall_cycles  out  CNT_W  consecutive block cycles counted.

Behaviour:
- Reset values: state=IDLE, all outputs 0, counter 0, snapshot 0.
- Counter rule: saturates at all-ones.
- IDLE: `block`=1 → ARM, counter=1. Otherwise stay, counter=0.
- ARM:
  - `block`=0 → IDLE, counter=0.
  - Otherwise counter+1.
  - If `block`=1 and counter==THRESH-1: latch `axis_block_info` into the snapshot and set `deadlock`=1 on that edge. `deadlock` is visible the cycle after the THRESH-th high sample.
  - Next state is EMIT if the snapshot is non-zero, else DONE (no records).
- EMIT:
  - `rpt_valid`=1 with the lowest-indexed non-zero snapshot field not yet sent. `rpt_code` is that field.
  - `rpt_last`=1 when no higher non-zero field remains.
  - Outputs are stable while `rpt_valid`=1 and `rpt_ready`=0.
  - On `rpt_valid`&`rpt_ready`, advance to the next field. After the handshake with `rpt_last`=1 → DONE and `rpt_valid` drops the next cycle.
- DONE: `deadlock` held at 1 and `stall_cycles` frozen. Input changes are ignored (see Optional Feature for the exception).
- `clear`:
  - Takes priority in every state: next state IDLE, `deadlock`=0, counter=0, snapshot=0, `rpt_valid`=0.
  - An in-flight record is dropped, even if `rpt_ready`=1 in the same cycle.
- `stall_cycles` tracks the counter in IDLE/ARM and freezes from the detection edge onward.
- `axis_block_info` is sampled only at the detection edge. Later changes do not alter records.
- `reset_n` low at any time (including mid-EMIT) returns all state to reset values immediately.

Optional Feature:
- Macro: DEADLOCK_REARM_EN.
- Defined: in DONE, a cycle with `block`=0 → IDLE with `deadlock`=0, counter=0, snapshot=0. `clear` still works as well.
- Undefined: DONE exits only via `clear` or reset.

Decomposition:
- Shared package `deadlock_pkg`:
  - state enum {IDLE, ARM, EMIT, DONE};
  - constant BLK_NONE=2'b00;
  - function `ch_field(vec,k)` extracting field k.
- One natural sub-module, `dl_chan_scan`: combinational next-set-channel finder. Inputs: snapshot and sent mask. Outputs: index, found, last.

Test Plan (NUM_CH=2, THRESH=4):
- `block` high for 3 cycles then low → `deadlock` stays 0; `stall_cycles` returns to 0; no `rpt_valid`.
- `block` high 4 cycles, info=4'b0110, `rpt_ready`=1 → `deadlock`=1 the cycle after the 4th high. Two records: (chan0, code 2'b10, last 0), then (chan1, code 2'b01, last 1). Then DONE.
- Same detection as above with `rpt_ready` held 0 for 5 cycles → record 0 held stable for 5 cycles. Info changed to 4'b0000 in that window → records unchanged.
- Detection with info=4'b0000 → `deadlock`=1, no `rpt_valid`, DONE. `clear` → `deadlock`=0, IDLE.
- `clear` asserted during EMIT with `rpt_ready`=1 → `rpt_valid` 0 the next cycle, no further records, `deadlock`=0. `reset_n` pulsed mid-EMIT → all outputs 0 asynchronously.
- DONE, then `block`=0 for 1 cycle → with DEADLOCK_REARM_EN: `deadlock`=0 next cycle. Without it: `deadlock` stays 1.
